ps2_scancode_decoder: RTL
=========================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two, >= 2.
REQ-002 SHALL have port clk  in  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_valid  in  1  one-cycle strobe from ps2_controller valid.
REQ-005 SHALL have port rx_data  in  8  received byte, qualified by rx_valid.
REQ-006 SHALL have port rx_flags  in  ps2_pkg::flags_t  controller error flags, qualified by rx_valid; any bit set = error.
REQ-007 SHALL have port ev_valid  out  1  key event available at queue head.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts the head event.
REQ-009 SHALL have port ev_code  out  8  scancode of the head event.
REQ-010 SHALL have port ev_ext  out  1  head event was E0-prefixed.
REQ-011 SHALL have port ev_brk  out  1  head event is a release (F0-prefixed).
REQ-012 SHALL have port ev_pause  out  1  head event is the Pause key.
REQ-013 SHALL have port bat_ok  out  1  one-cycle pulse on device self-test pass.
REQ-014 SHALL have port err  out  1  one-cycle pulse on any discarded or erroneous byte.
REQ-015 SHALL have port ovf  out  1  sticky: an event was dropped because the queue was full.

Function
REQ-016 SHALL act only on cycles with rx_valid=1.
- Byte accepted in cycle N.
- Resulting bat_ok/err pulse in cycle N+1.
- Resulting event visible on ev_* in cycle N+1 when the queue was empty.
REQ-017 SHALL implement the FSM states IDLE, EXT, BRK, EXT_BRK and PAUSE.
REQ-018 SHALL make the following transitions on an error-free byte:
- IDLE + E0 -> EXT.
- IDLE + F0 -> BRK.
- EXT + F0 -> EXT_BRK.
- IDLE + E1 -> PAUSE, with skip counter loaded to 7.
REQ-019 SHALL, on any other error-free byte in IDLE/EXT/BRK/EXT_BRK:
- Push event {code=byte, ext=(EXT|EXT_BRK), brk=(BRK|EXT_BRK), pause=0}.
- Return to IDLE.
REQ-020 SHALL, in PAUSE, decrement the skip counter on each byte.
- On the byte that brings the counter to 0: push {code=77h, ext=0, brk=0, pause=1} and return to IDLE.
- Skipped bytes produce no events.
REQ-021 SHALL, in IDLE only, treat special bytes as follows; none produces an event:
- AAh: pulse bat_ok.
- FCh, 00h, FFh: pulse err.
- FAh, FEh, EEh: ignore.
REQ-022 SHALL, on a prefix byte arriving in any non-IDLE state (e.g. E0 in EXT, F0 in BRK):
- Pulse err.
- Discard the partial sequence.
- Re-interpret the byte from IDLE.
REQ-023 SHALL, on rx_valid with |rx_flags:
- Discard the byte.
- Pulse err.
- Force IDLE and clear the skip counter.
- Push no event.
REQ-024 SHALL implement the event queue as a FIFO_DEPTH-entry show-ahead FIFO.
- ev_* reflect the head entry.
- A pop occurs when ev_valid & ev_ready.
REQ-025 SHALL, on a push while the queue is full and no pop occurs in the same cycle:
- Drop the new event.
- Set ovf=1.
- Leave the queue contents unchanged.
REQ-026 SHALL perform both push and pop when they coincide on a full queue; no drop, no ovf.
REQ-027 SHALL keep ev_code/ev_ext/ev_brk/ev_pause stable while ev_valid=1 and ev_ready=0.
REQ-028 SHALL wrap the read and write pointers modulo FIFO_DEPTH and keep an occupancy count 0..FIFO_DEPTH.

Reset
REQ-029 SHALL, while rst_n=0, force: FSM=IDLE, skip counter=0, queue empty, ev_valid=0, ev_code=00h, ev_ext=ev_brk=ev_pause=0, bat_ok=0, err=0, ovf=0.
REQ-030 SHALL discard any partial prefix or Pause sequence when reset is asserted mid-sequence.
REQ-031 SHALL clear ovf only by reset.

Verification
REQ-032 SHALL cover: 1Ch with ev_ready=1 -> in cycle N+1, ev_valid=1, code=1Ch, ext=0, brk=0, pause=0; popped the same cycle.
REQ-033 SHALL cover: E0,F0,75h -> exactly one event, code=75h, ext=1, brk=1; F0,1Ch -> code=1Ch, ext=0, brk=1.
REQ-034 SHALL cover: E1,14,77,E1,F0,14,F0,77 -> exactly one event, code=77h, pause=1; no err.
REQ-035 SHALL cover: E0, then a byte with rx_flags!=0, then 1Ch -> err pulse once; event code=1Ch, ext=0.
REQ-036 SHALL cover: ev_ready=0 with makes 01h..05h (FIFO_DEPTH=4) -> ovf=1 after the fifth byte; with ev_ready=1 the drain order is 01h..04h, then ev_valid=0.
REQ-037 SHALL cover both:
- AAh -> bat_ok pulse, no event; FCh -> err pulse.
- E0, then rst_n low then high, then 1Ch -> event ext=0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode decoder: folds E0/F0/E1 prefix sequences into key events
// and queues them in a small show-ahead FIFO.
package ps2_pkg;
    typedef struct packed {
        logic timeout;
        logic frame_err;
        logic parity_err;
    } flags_t;
endpackage

module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    input  ps2_pkg::flags_t rx_flags,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [7:0]      ev_code,
    output logic            ev_ext,
    output logic            ev_brk,
    output logic            ev_pause,
    output logic            bat_ok,
    output logic            err,
    output logic            ovf
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    typedef struct packed {
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    state_t state, state_n;
    logic [2:0] skip, skip_n;

    logic [$bits(ps2_pkg::flags_t)-1:0] flags_vec;
    logic rx_bad, rx_ok, is_prefix, restart, from_idle;
    logic push, err_set, bat_set;
    ev_t  push_ev, head;

    assign flags_vec = rx_flags;
    assign rx_bad    = rx_valid & (|flags_vec);
    assign rx_ok     = rx_valid & ~(|flags_vec);
    assign is_prefix = (rx_data == 8'hE0) || (rx_data == 8'hF0) || (rx_data == 8'hE1);
    // A prefix that cannot extend the pending sequence aborts it and starts afresh
    assign restart   = rx_ok && is_prefix && (state inside {EXT, BRK, EXT_BRK})
                       && !(state == EXT && rx_data == 8'hF0);
    assign from_idle = (state == IDLE) || restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            skip  <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip;
        if (rx_bad) begin
            state_n = IDLE;
            skip_n  = '0;
        end else if (rx_ok) begin
            if (state == PAUSE) begin
                skip_n = skip - 3'd1;
                if (skip == 3'd1) state_n = IDLE;
            end else if (from_idle) begin
                unique case (rx_data)
                    8'hE0:   state_n = EXT;
                    8'hF0:   state_n = BRK;
                    8'hE1: begin
                        state_n = PAUSE;
                        skip_n  = 3'd7;
                    end
                    default: state_n = IDLE;
                endcase
            end else if (state == EXT && rx_data == 8'hF0) begin
                state_n = EXT_BRK;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_comb begin
        push    = 1'b0;
        push_ev = '0;
        err_set = 1'b0;
        bat_set = 1'b0;
        if (rx_bad) begin
            err_set = 1'b1;
        end else if (rx_ok) begin
            if (state == PAUSE) begin
                if (skip == 3'd1) begin
                    push    = 1'b1;
                    push_ev = '{pause: 1'b1, brk: 1'b0, ext: 1'b0, code: 8'h77};
                end
            end else begin
                err_set = restart;
                if (from_idle) begin
                    unique case (rx_data)
                        8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hFE, 8'hEE: ;
                        8'hAA:               bat_set = 1'b1;
                        8'hFC, 8'h00, 8'hFF: err_set = 1'b1;
                        default: begin
                            push    = 1'b1;
                            push_ev = '{pause: 1'b0, brk: 1'b0, ext: 1'b0, code: rx_data};
                        end
                    endcase
                end else if (!(state == EXT && rx_data == 8'hF0)) begin
                    push    = 1'b1;
                    push_ev = '{pause: 1'b0,
                                brk:   (state == BRK) || (state == EXT_BRK),
                                ext:   (state == EXT) || (state == EXT_BRK),
                                code:  rx_data};
                end
            end
        end
    end

    ev_t mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          full, pop, do_push;

    assign full    = (count == FULL_CNT);
    assign pop     = ev_valid & ev_ready;
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            bat_ok <= 1'b0;
        end else begin
            err    <= err_set;
            bat_ok <= bat_set;
            if (push && full && !pop) ovf <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_ev;
    end

    assign ev_valid = (count != '0);
    assign head     = ev_valid ? mem[rd_ptr] : '0;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_brk   = head.brk;
    assign ev_pause = head.pause;

endmodule
